// File: rtl/output_stream_reader.sv
// output_stream_reader: drains the unified output BRAM bank one row at a time
// and serializes the NUM_BRAMS lanes of each row onto an AXI-Stream master,
// lane 0 first, with optional per-lane ReLU applied when the row is captured.
module output_stream_reader #(
    parameter int DW         = 16,
    parameter int NUM_BRAMS  = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 1024
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [ADDR_WIDTH-1:0]           base_addr,
    input  logic [ADDR_WIDTH:0]             num_rows,
    input  logic                            conv_mode,
    input  logic                            relu_en,
    output logic                            busy,
    output logic                            done,
    output logic                            ext_read_mode,
    output logic [NUM_BRAMS*ADDR_WIDTH-1:0] ext_read_addr_flat,
    output logic [NUM_BRAMS-1:0]            ext_enb,
    input  logic [NUM_BRAMS*DW-1:0]         bram_read_data_flat,
    output logic [DW-1:0]                   m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast
);

    localparam int LANE_W = (NUM_BRAMS > 1) ? $clog2(NUM_BRAMS) : 1;
    localparam int ROW_W  = ADDR_WIDTH + 1;

    localparam logic [LANE_W-1:0]     LAST_LANE = LANE_W'(NUM_BRAMS - 1);
    localparam logic [ROW_W-1:0]      ROW_ONE   = ROW_W'(1);
    localparam logic [ROW_W-1:0]      ROW_MAX   = ROW_W'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_STREAM,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    // Job parameters latched at start
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ROW_W-1:0]      nrows_q;
    logic                  lat2_q;      // 1: two-cycle read latency (1DCONV)
    logic                  relu_q;

    // Progress counters
    logic [ROW_W-1:0]      row_q;
    logic [LANE_W-1:0]     lane_q;
    logic                  wait_q;
    logic [ADDR_WIDTH-1:0] addr_q;

    logic [DW-1:0]           row_buf [NUM_BRAMS];
    logic [NUM_BRAMS*DW-1:0] capt_flat;
    logic [ROW_W-1:0]        start_rows;

    logic beat;
    logic lane_last;
    logic row_last;
    logic wait_last;

    // Requests beyond the bank depth are limited to one full pass of the bank
    assign start_rows = (num_rows > ROW_MAX) ? ROW_MAX : num_rows;

    assign beat      = (state_q == S_STREAM) && m_axis_tready;
    assign lane_last = (lane_q == LAST_LANE);
    assign row_last  = (row_q == (nrows_q - ROW_ONE));
    assign wait_last = !lat2_q || wait_q;

    assign ext_read_addr_flat = {NUM_BRAMS{addr_q}};

    // Per-lane ReLU on the incoming bank row: negative lanes become zero
    always_comb begin
        capt_flat = bram_read_data_flat;
        for (int unsigned i = 0; i < NUM_BRAMS; i++) begin
            if (relu_q && bram_read_data_flat[i*DW + DW - 1]) begin
                capt_flat[i*DW +: DW] = '0;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d       = state_q;
        busy          = 1'b0;
        done          = 1'b0;
        ext_read_mode = 1'b0;
        ext_enb       = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (start_rows == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                busy          = 1'b1;
                ext_read_mode = 1'b1;
                ext_enb       = '1;
                state_d       = S_WAIT;
            end
            S_WAIT: begin
                busy          = 1'b1;
                ext_read_mode = 1'b1;
                if (wait_last) begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                busy          = 1'b1;
                ext_read_mode = 1'b1;
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = row_buf[lane_q];
                m_axis_tlast  = lane_last && row_last;
                if (beat && lane_last) begin
                    state_d = row_last ? S_DONE : S_READ;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Job latch, counters, read address and row buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q  <= '0;
            nrows_q <= '0;
            lat2_q  <= 1'b0;
            relu_q  <= 1'b0;
            row_q   <= '0;
            lane_q  <= '0;
            wait_q  <= 1'b0;
            addr_q  <= '0;
            for (int unsigned i = 0; i < NUM_BRAMS; i++) begin
                row_buf[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        base_q  <= base_addr;
                        nrows_q <= start_rows;
                        lat2_q  <= ~conv_mode;
                        relu_q  <= relu_en;
                        row_q   <= '0;
                        lane_q  <= '0;
                        if (start_rows != '0) begin
                            addr_q <= base_addr;
                        end
                    end
                end
                S_READ: begin
                    wait_q <= 1'b0;
                end
                S_WAIT: begin
                    wait_q <= 1'b1;
                    if (wait_last) begin
                        lane_q <= '0;
                        for (int unsigned i = 0; i < NUM_BRAMS; i++) begin
                            row_buf[i] <= capt_flat[i*DW +: DW];
                        end
                    end
                end
                S_STREAM: begin
                    if (beat) begin
                        if (lane_last) begin
                            lane_q <= '0;
                            row_q  <= row_q + ROW_ONE;
                            // Next row address is computed here so it is already
                            // stable on the bank port during the following READ.
                            addr_q <= base_q + row_q[ADDR_WIDTH-1:0] + ADDR_ONE;
                        end else begin
                            lane_q <= lane_q + LANE_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_output_stream_reader.sv
// Self-checking bench for output_stream_reader: a behavioural BRAM bank with
// mode-dependent read latency, and a per-job reference built from the bank
// contents (row order, wrap, ReLU) compared beat by beat on the stream.
`timescale 1ns/1ps
module tb_output_stream_reader;

    localparam int DW    = 16;
    localparam int NB    = 16;
    localparam int AW    = 10;
    localparam int DEPTH = 1024;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [AW-1:0]     base_addr;
    logic [AW:0]       num_rows;
    logic              conv_mode;
    logic              relu_en;
    logic              busy;
    logic              done;
    logic              ext_read_mode;
    logic [NB*AW-1:0]  ext_read_addr_flat;
    logic [NB-1:0]     ext_enb;
    logic [NB*DW-1:0]  bram_read_data_flat;
    logic [DW-1:0]     m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0]    mem [DEPTH][NB];
    logic             tb_trans = 1'b1;
    logic [NB*DW-1:0] s1_flat = '0;
    logic [NB*DW-1:0] s2_flat = '0;

    always #5 clk = ~clk;

    output_stream_reader #(
        .DW(DW),
        .NUM_BRAMS(NB),
        .ADDR_WIDTH(AW),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .base_addr(base_addr),
        .num_rows(num_rows),
        .conv_mode(conv_mode),
        .relu_en(relu_en),
        .busy(busy),
        .done(done),
        .ext_read_mode(ext_read_mode),
        .ext_read_addr_flat(ext_read_addr_flat),
        .ext_enb(ext_enb),
        .bram_read_data_flat(bram_read_data_flat),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast)
    );

    // Bank model: stage 1 holds data only in the cycle right after an enabled
    // read (junk otherwise), stage 2 is one cycle later.
    always @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (ext_enb[i]) s1_flat[i*DW +: DW] <= mem[ext_read_addr_flat[i*AW +: AW]][i];
            else            s1_flat[i*DW +: DW] <= DW'($urandom);
        end
        s2_flat <= s1_flat;
    end
    assign bram_read_data_flat = tb_trans ? s1_flat : s2_flat;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_job(input int base, input int nrows, input bit trans,
                           input bit relu, input int pct, input bit poke_start);
        logic [DW-1:0] expq[$];
        logic [DW-1:0] v;
        logic [DW-1:0] prev_d;
        logic          prev_l;
        logic [AW-1:0] exp_addr;
        int L, total, acc, reads, cyc, first_valid, last_acc, exp_done_cyc;
        bit prev_v, prev_r, finished, done_seen, exp_done;
        L = trans ? 1 : 2;
        for (int r = 0; r < nrows; r++) begin
            for (int i = 0; i < NB; i++) begin
                v = mem[(base + r) % DEPTH][i];
                if (relu && v[DW-1]) v = '0;
                expq.push_back(v);
            end
        end
        total = expq.size();
        acc = 0; reads = 0; cyc = 0; first_valid = -1; last_acc = 0; exp_done_cyc = -1;
        prev_v = 0; prev_r = 0; prev_d = '0; prev_l = 0; finished = 0; done_seen = 0;
        tb_trans = trans;

        @(posedge clk); #1;
        start = 1'b1; base_addr = AW'(base); num_rows = (AW+1)'(nrows);
        conv_mode = trans; relu_en = relu;
        m_axis_tready = ($urandom_range(99) < pct);
        @(negedge clk);
        chk("busy_cycle0", busy, 0);

        while (!finished && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            start     = poke_start && (nrows > 0) && (cyc == 5);
            base_addr = AW'($urandom);
            num_rows  = (AW+1)'($urandom);
            conv_mode = 1'($urandom);
            relu_en   = 1'($urandom);
            m_axis_tready = ($urandom_range(99) < pct);
            @(negedge clk);
            if (done_seen) begin
                chk("idle_after_done", {busy, done, ext_read_mode, m_axis_tvalid, |ext_enb}, 0);
                finished = 1;
            end else begin
                exp_done = (acc == total) && (cyc == last_acc + 1);
                chk("done", done, exp_done);
                if (exp_done) begin
                    exp_done_cyc = cyc;
                    done_seen = 1;
                    chk("busy_at_done", busy, 0);
                    chk("mode_at_done", ext_read_mode, 0);
                end else begin
                    chk("busy", busy, nrows > 0);
                    chk("ext_read_mode", ext_read_mode, nrows > 0);
                end
                if (ext_enb !== '0) begin
                    chk("enb_all_ones", ext_enb, {NB{1'b1}});
                    chk("read_within_job", reads < nrows, 1);
                    exp_addr = AW'((base + reads) % DEPTH);
                    for (int i = 0; i < NB; i++)
                        chk("read_addr", ext_read_addr_flat[i*AW +: AW], exp_addr);
                    reads++;
                end
                if (prev_v && !prev_r) begin
                    chk("stall_tvalid_held", m_axis_tvalid, 1);
                    chk("stall_tdata_held", m_axis_tdata, prev_d);
                    chk("stall_tlast_held", m_axis_tlast, prev_l);
                end
                if (m_axis_tvalid) begin
                    if (first_valid < 0) begin
                        first_valid = cyc;
                        chk("first_tvalid_cycle", cyc, 2 + L);
                    end
                    if (acc < total) begin
                        chk("tdata", m_axis_tdata, expq[acc]);
                        chk("tlast", m_axis_tlast, acc == total - 1);
                    end else begin
                        chk("extra_beat", 1, 0);
                    end
                    if (m_axis_tready) begin
                        acc++;
                        last_acc = cyc;
                    end
                end
                prev_v = m_axis_tvalid; prev_r = m_axis_tready;
                prev_d = m_axis_tdata;  prev_l = m_axis_tlast;
            end
        end
        start = 1'b0;
        chk("job_finished_in_budget", finished, 1);
        chk("beats_accepted", acc, total);
        chk("rows_read", reads, nrows);
        if (pct >= 100 && nrows > 0)
            chk("done_cycle_full_rate", exp_done_cyc, 2 + L + nrows*NB + (nrows-1)*(L+1));
        if (nrows == 0)
            chk("done_cycle_empty", exp_done_cyc, 1);
    endtask

    task automatic reset_midjob();
        int cnt, cyc;
        cnt = 0; cyc = 0;
        tb_trans = 1'b1;
        @(posedge clk); #1;
        start = 1'b1; base_addr = '0; num_rows = 11'd2; conv_mode = 1'b1; relu_en = 1'b0;
        m_axis_tready = 1'b1;
        while (cnt < 5 && cyc < 200) begin
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            @(negedge clk);
            if (m_axis_tvalid && m_axis_tready) cnt++;
        end
        chk("reached_beat5", cnt, 5);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mode", ext_read_mode, 0);
        chk("rst_addr", |ext_read_addr_flat, 0);
        chk("rst_enb", ext_enb, 0);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        @(negedge clk);
        chk("rst_hold_tvalid", {m_axis_tvalid, done, busy}, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; num_rows = '0;
        conv_mode = 1'b0; relu_en = 1'b0; m_axis_tready = 1'b0;
        for (int r = 0; r < DEPTH; r++)
            for (int i = 0; i < NB; i++)
                mem[r][i] = DW'($urandom);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NB; i++)
                mem[r][i] = DW'(r*16 + i);
        for (int i = 0; i < NB; i++) begin
            case (i % 4)
                0: mem[100][i] = 16'h8000;
                1: mem[100][i] = 16'hFFFF;
                2: mem[100][i] = 16'h0000;
                default: mem[100][i] = 16'h7FFF;
            endcase
        end

        #2;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_mode", ext_read_mode, 0);
        chk("reset_addr", |ext_read_addr_flat, 0);
        chk("reset_enb", ext_enb, 0);
        chk("reset_tvalid", m_axis_tvalid, 0);
        chk("reset_tlast", m_axis_tlast, 0);
        chk("reset_tdata", m_axis_tdata, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        run_job(0, 2, 1'b1, 1'b0, 100, 1'b1);
        run_job(0, 2, 1'b0, 1'b0, 100, 1'b0);
        run_job(int'($urandom_range(DEPTH-1)), 4, 1'b1, 1'($urandom), 50, 1'b1);
        run_job(int'($urandom_range(DEPTH-1)), 4, 1'b0, 1'($urandom), 50, 1'b0);
        run_job(100, 1, 1'b1, 1'b1, 100, 1'b0);
        run_job(100, 1, 1'b0, 1'b0, 100, 1'b0);
        run_job(1023, 2, 1'b1, 1'b0, 100, 1'b0);
        run_job(0, 0, 1'b1, 1'b0, 100, 1'b1);
        reset_midjob();
        run_job(0, 2, 1'b0, 1'b1, 100, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
